vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the danmaku image pipeline. It produces horizontal/vertical sync, a visible-area flag and the current pixel position for any VGA-style mode, plus line/frame markers and a frame counter. A look-ahead position port lets the pixel-fetch stage (font ROM / framebuffer) start reads a fixed number of pixel clocks before the pixel is displayed. It sits between the pixel clock source and the image generator / DAC output stage.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- CNT_W, 13, width of position counters
- LOOKAHEAD, 2, fetch lead in enabled clocks; legal range 0..H_TOTAL-1
- FRAME_W, 8, frame counter width

Derived: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 default), V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 default). Both must fit in CNT_W bits.

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; when 0 all state holds
- hcnt  out  CNT_W  current column, 0..H_TOTAL-1
- vcnt  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per HSYNC_POL
- vsync  out  1  vertical sync, level per VSYNC_POL
- visible_area  out  1  hcnt<H_VISIBLE and vcnt<V_VISIBLE
- line_start  out  1  high while hcnt==0
- frame_start  out  1  high while hcnt==0 and vcnt==0
- frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W
- fetch_x  out  CNT_W  column displayed LOOKAHEAD enabled clocks from now
- fetch_y  out  CNT_W  line displayed LOOKAHEAD enabled clocks from now
- fetch_valid  out  1  (fetch_x,fetch_y) lies in the visible area

## Operation
- Main counter: on each pixel_clk edge with en=1, hcnt increments; at hcnt==H_TOTAL-1 it wraps to 0 and vcnt increments; at vcnt==V_TOTAL-1 with hcnt wrap, vcnt wraps to 0 and frame_cnt increments (modulo 2^FRAME_W).
- hsync asserted (=HSYNC_POL) for H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC, else ~HSYNC_POL. vsync likewise on vcnt with V_* values.
- All outputs are flip-flop outputs (no combinational decode on output pins), each computed from the next counter value so that hsync, vsync, visible_area, line_start, frame_start describe the hcnt/vcnt presented in the same cycle.
- Look-ahead counter: independent (fetch_x,fetch_y) pair advanced under the same en and the same wrap rules; it always equals the main position advanced by LOOKAHEAD steps with line and frame wrap. LOOKAHEAD=0 makes fetch_* identical to hcnt/vcnt.
- en=0: every register holds; markers stay at their current level (line_start/frame_start are levels, not single-cycle pulses).

## Timing
- Reset values: hcnt=0, vcnt=0, frame_cnt=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, visible_area=1, line_start=1, frame_start=1, fetch_x=LOOKAHEAD, fetch_y=0, fetch_valid=(LOOKAHEAD<H_VISIBLE).
- Reset asserted mid-frame forces the reset values immediately (asynchronous); the first advance after deassertion takes hcnt to 1.
- Latency from en=1 edge to updated position and decoded flags: 1 clock; no extra pipeline skew between any outputs.
- Frame boundary: the edge leaving (H_TOTAL-1, V_TOTAL-1) sets hcnt=0, vcnt=0, frame_start=1 and frame_cnt+1 together.
- Look-ahead wrap: with default LOOKAHEAD=2, at (798,v) fetch=(0,v+1); at (798,524) fetch=(0,0); at (799,524) fetch=(1,0).
- frame_cnt at 2^FRAME_W-1 wraps to 0 with no flag.

## Test plan
- Reset, en=1, defaults: hsync low exactly for hcnt 656..751 on line 0; visible_area high for hcnt 0..639, low at 640; line_start high only at hcnt 0.
- Full frame: vsync low for vcnt 490..491 (1600 clocks); after 420000 enabled clocks hcnt=vcnt=0, frame_start=1, frame_cnt=1.
- Stall: toggle en low for 5 clocks at hcnt=655 -> all outputs frozen, hsync asserts on the first enabled edge reaching 656; total frame length counts only enabled clocks.
- Look-ahead: LOOKAHEAD=2, check fetch_x/fetch_y/fetch_valid against hcnt/vcnt delayed by 2 over a whole frame, including the frame wrap values listed above; repeat with LOOKAHEAD=0.
- Polarity/small mode: H=8/2/2/2, V=4/1/1/1, HSYNC_POL=1, VSYNC_POL=1, FRAME_W=2 -> hsync high for hcnt 10..11, vsync high on vcnt 5, frame_cnt wraps 3->0 after 4 frames of 98 clocks.
- Async reset asserted at (300,200) for a partial clock -> outputs return to reset values without a clock edge; restart from (0,0).

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The generator side (master) owns every timing output and samples en.
// The consumer side (slave) drives en and observes the raster.
interface vga_timing_if #(
  parameter int unsigned CNT_W   = 13,
  parameter int unsigned FRAME_W = 8
);

  logic               en;
  logic [CNT_W-1:0]   hcnt;
  logic [CNT_W-1:0]   vcnt;
  logic               hsync;
  logic               vsync;
  logic               visible_area;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic [CNT_W-1:0]   fetch_x;
  logic [CNT_W-1:0]   fetch_y;
  logic               fetch_valid;

  modport master (
    input  en,
    output hcnt,
    output vcnt,
    output hsync,
    output vsync,
    output visible_area,
    output line_start,
    output frame_start,
    output frame_cnt,
    output fetch_x,
    output fetch_y,
    output fetch_valid
  );

  modport slave (
    output en,
    input  hcnt,
    input  vcnt,
    input  hsync,
    input  vsync,
    input  visible_area,
    input  line_start,
    input  frame_start,
    input  frame_cnt,
    input  fetch_x,
    input  fetch_y,
    input  fetch_valid
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA-style raster timing generator.
// A main (hcnt, vcnt) counter drives sync, visible-area and line/frame markers; a second
// counter pair runs LOOKAHEAD positions ahead so the fetch stage can issue reads early.
// Every output is a flop, decoded from the next counter value so that flags and position
// presented in the same cycle always agree.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 13,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned FRAME_W   = 8
) (
  input  logic         pixel_clk,
  input  logic         rst,
  vga_timing_if.master bus
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] FETCH_X0   = CNT_W'(LOOKAHEAD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Elaboration-time sanity of the mode parameters.
  if (((H_TOTAL - 1) >> CNT_W) != 0) begin : g_h_total_chk
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (((V_TOTAL - 1) >> CNT_W) != 0) begin : g_v_total_chk
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (LOOKAHEAD >= H_TOTAL) begin : g_lookahead_chk
    $error("LOOKAHEAD must be below H_TOTAL");
  end

  // Sync level for a given column / line.
  function automatic logic hsync_lvl(input logic [CNT_W-1:0] x);
    return (x >= H_SYNC_BEG && x < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
  endfunction

  function automatic logic vsync_lvl(input logic [CNT_W-1:0] y);
    return (y >= V_SYNC_BEG && y < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
  endfunction

  function automatic logic in_visible(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
    return (x < H_VIS_END) && (y < V_VIS_END);
  endfunction

  // Main raster position and frame count.
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  // Look-ahead position, same wrap rules as the main counter.
  logic [CNT_W-1:0]   fx_q, fx_d;
  logic [CNT_W-1:0]   fy_q, fy_d;

  // Registered decodes.
  logic hsync_q, vsync_q, visible_q, line_start_q, frame_start_q, fetch_valid_q;

  logic h_wrap, v_wrap, fx_wrap, fy_wrap;

  // Next main position: column wraps into the next line, last line wraps into the next frame.
  always_comb begin
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    h_d     = h_wrap ? '0 : h_q + CNT_ONE;
    v_d     = v_q;
    frame_d = frame_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_d     = '0;
        frame_d = frame_q + FRAME_W'(1);
      end else begin
        v_d = v_q + CNT_ONE;
      end
    end
  end

  // Next look-ahead position; kept as its own counter so no adder on the fetch path.
  always_comb begin
    fx_wrap = (fx_q == H_LAST);
    fy_wrap = (fy_q == V_LAST);
    fx_d    = fx_wrap ? '0 : fx_q + CNT_ONE;
    fy_d    = fy_q;
    if (fx_wrap) begin
      fy_d = fy_wrap ? '0 : fy_q + CNT_ONE;
    end
  end

  // Counter state; everything holds while en is low.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      fx_q    <= FETCH_X0;
      fy_q    <= '0;
    end else if (bus.en) begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
    end
  end

  // Output flags decoded from the next position so they line up with hcnt/vcnt.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= hsync_lvl('0);
      vsync_q       <= vsync_lvl('0);
      visible_q     <= in_visible('0, '0);
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      fetch_valid_q <= in_visible(FETCH_X0, '0);
    end else if (bus.en) begin
      hsync_q       <= hsync_lvl(h_d);
      vsync_q       <= vsync_lvl(v_d);
      visible_q     <= in_visible(h_d, v_d);
      line_start_q  <= (h_d == '0);
      frame_start_q <= (h_d == '0) && (v_d == '0);
      fetch_valid_q <= in_visible(fx_d, fy_d);
    end
  end

  assign bus.hcnt         = h_q;
  assign bus.vcnt         = v_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.visible_area = visible_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_cnt    = frame_q;
  assign bus.fetch_x      = fx_q;
  assign bus.fetch_y      = fy_q;
  assign bus.fetch_valid  = fetch_valid_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances share clock, reset and enable.
//   dut0: full default 640x480 mode, LOOKAHEAD=2
//   dut1: default line timing, 15-line frame (vsync on lines 10..11), LOOKAHEAD=2
//   dut2: as dut1 with LOOKAHEAD=0
//   dut3: 8/2/2/2 x 4/1/1/1 mode, active-high syncs, FRAME_W=2, LOOKAHEAD=3
// An arithmetic raster model per instance pushes expected outputs into a queue on every
// driven cycle; each test pops and compares them against the sampled outputs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [12:0] hcnt;
    logic [12:0] vcnt;
    logic        hsync;
    logic        vsync;
    logic        vis;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
    logic [12:0] fx;
    logic [12:0] fy;
    logic        fv;
  } obs_t;

  typedef struct {
    int unsigned hv, hfp, hs, hbp;
    int unsigned vv, vfp, vs, vbp;
    int unsigned hpol, vpol, la, fw;
  } cfg_t;

  logic pixel_clk = 1'b0;
  logic rst       = 1'b1;
  logic en        = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_if #(.CNT_W(13), .FRAME_W(8)) bus0 ();
  vga_timing_if #(.CNT_W(13), .FRAME_W(8)) bus1 ();
  vga_timing_if #(.CNT_W(13), .FRAME_W(8)) bus2 ();
  vga_timing_if #(.CNT_W(13), .FRAME_W(2)) bus3 ();

  assign bus0.en = en;
  assign bus1.en = en;
  assign bus2.en = en;
  assign bus3.en = en;

  vga_timing_gen #(.LOOKAHEAD(2)) dut0 (.pixel_clk(pixel_clk), .rst(rst), .bus(bus0));

  vga_timing_gen #(
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .LOOKAHEAD(2)
  ) dut1 (.pixel_clk(pixel_clk), .rst(rst), .bus(bus1));

  vga_timing_gen #(
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .LOOKAHEAD(0)
  ) dut2 (.pixel_clk(pixel_clk), .rst(rst), .bus(bus2));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FRAME_W(2), .LOOKAHEAD(3)
  ) dut3 (.pixel_clk(pixel_clk), .rst(rst), .bus(bus3));

  obs_t got [4];

  // Sampled DUT outputs, packed per instance.
  always_comb begin
    got[0] = {bus0.hcnt, bus0.vcnt, bus0.hsync, bus0.vsync, bus0.visible_area,
              bus0.line_start, bus0.frame_start, bus0.frame_cnt,
              bus0.fetch_x, bus0.fetch_y, bus0.fetch_valid};
    got[1] = {bus1.hcnt, bus1.vcnt, bus1.hsync, bus1.vsync, bus1.visible_area,
              bus1.line_start, bus1.frame_start, bus1.frame_cnt,
              bus1.fetch_x, bus1.fetch_y, bus1.fetch_valid};
    got[2] = {bus2.hcnt, bus2.vcnt, bus2.hsync, bus2.vsync, bus2.visible_area,
              bus2.line_start, bus2.frame_start, bus2.frame_cnt,
              bus2.fetch_x, bus2.fetch_y, bus2.fetch_valid};
    got[3] = {bus3.hcnt, bus3.vcnt, bus3.hsync, bus3.vsync, bus3.visible_area,
              bus3.line_start, bus3.frame_start, 6'd0, bus3.frame_cnt,
              bus3.fetch_x, bus3.fetch_y, bus3.fetch_valid};
  end

  cfg_t        cfg [4];
  int unsigned mh [4];
  int unsigned mv [4];
  int unsigned mfc [4];
  obs_t        exp_q [$];
  obs_t        exp_v;
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic obs_t model_out(input int k);
    obs_t        o;
    cfg_t        c;
    int unsigned ht, vt, pos, fx, fy, h, v;
    c  = cfg[k];
    h  = mh[k];
    v  = mv[k];
    ht = c.hv + c.hfp + c.hs + c.hbp;
    vt = c.vv + c.vfp + c.vs + c.vbp;
    o.hcnt  = 13'(h);
    o.vcnt  = 13'(v);
    o.hsync = (h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hs) ? 1'(c.hpol) : ~1'(c.hpol);
    o.vsync = (v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vs) ? 1'(c.vpol) : ~1'(c.vpol);
    o.vis   = (h < c.hv) && (v < c.vv);
    o.ls    = (h == 0);
    o.fs    = (h == 0) && (v == 0);
    o.fc    = 8'(mfc[k]);
    pos     = (v * ht + h + c.la) % (ht * vt);
    fx      = pos % ht;
    fy      = pos / ht;
    o.fx    = 13'(fx);
    o.fy    = 13'(fy);
    o.fv    = (fx < c.hv) && (fy < c.vv);
    return o;
  endfunction

  task automatic reset_models();
    for (int k = 0; k < 4; k++) begin
      mh[k]  = 0;
      mv[k]  = 0;
      mfc[k] = 0;
    end
  endtask

  task automatic step_model(input int k);
    int unsigned ht, vt;
    ht = cfg[k].hv + cfg[k].hfp + cfg[k].hs + cfg[k].hbp;
    vt = cfg[k].vv + cfg[k].vfp + cfg[k].vs + cfg[k].vbp;
    if (mh[k] == ht - 1) begin
      mh[k] = 0;
      if (mv[k] == vt - 1) begin
        mv[k]  = 0;
        mfc[k] = (mfc[k] + 1) % (1 << cfg[k].fw);
      end else begin
        mv[k] = mv[k] + 1;
      end
    end else begin
      mh[k] = mh[k] + 1;
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < 4; k++) exp_q.push_back(model_out(k));
  endtask

  // One clock with the given enable; returns #1 after the edge with expectations queued.
  task automatic drive_cycle(input logic e);
    en = e;
    @(posedge pixel_clk);
    if (rst) reset_models();
    else if (e) for (int k = 0; k < 4; k++) step_model(k);
    push_expected();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    reset_models();
    push_expected();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vectors++;
      if (got[k] !== exp_v) begin
        miscompares++;
        $display("FAIL reset dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
      end
    end
    #2 rst = 1'b0;
    // en low after release: reset values must hold.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  task automatic test_first_line();
    for (int i = 0; i < 800; i++) begin
      drive_cycle(1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL first_line dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  // Reach column 655 of line 1, freeze for 5 clocks, then cross into hsync.
  task automatic test_stall();
    for (int i = 0; i < 655 + 5 + 4; i++) begin
      drive_cycle((i >= 655 && i < 660) ? 1'b0 : 1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL stall dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  // Crosses the 15-line frame boundary of dut1/dut2, including look-ahead wrap.
  task automatic test_full_frame();
    for (int i = 0; i < 12100; i++) begin
      drive_cycle(1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL full_frame dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  // Several 98-clock frames of the small mode with sporadic stalls; frame_cnt wraps 3->0.
  task automatic test_small_mode();
    for (int i = 0; i < 5 * 98; i++) begin
      drive_cycle((i % 37 == 36) ? 1'b0 : 1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL small_mode dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  // Reset pulse between edges must clear outputs at once; restart counts from (0,0).
  task automatic test_async_reset();
    #1 rst = 1'b1;
    #1;
    reset_models();
    push_expected();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      vectors++;
      if (got[k] !== exp_v) begin
        miscompares++;
        $display("FAIL async_reset dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
      end
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b1);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        vectors++;
        if (got[k] !== exp_v) begin
          miscompares++;
          $display("FAIL restart dut%0d t=%0t got=%h exp=%h", k, $time, got[k], exp_v);
        end
      end
    end
  endtask

  initial begin
    cfg[0] = '{hv: 640, hfp: 16, hs: 96, hbp: 48, vv: 480, vfp: 10, vs: 2, vbp: 33,
               hpol: 0, vpol: 0, la: 2, fw: 8};
    cfg[1] = '{hv: 640, hfp: 16, hs: 96, hbp: 48, vv: 8, vfp: 2, vs: 2, vbp: 3,
               hpol: 0, vpol: 0, la: 2, fw: 8};
    cfg[2] = '{hv: 640, hfp: 16, hs: 96, hbp: 48, vv: 8, vfp: 2, vs: 2, vbp: 3,
               hpol: 0, vpol: 0, la: 0, fw: 8};
    cfg[3] = '{hv: 8, hfp: 2, hs: 2, hbp: 2, vv: 4, vfp: 1, vs: 1, vbp: 1,
               hpol: 1, vpol: 1, la: 3, fw: 2};
    reset_models();
    test_reset();
    test_first_line();
    test_stall();
    test_full_frame();
    test_small_mode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
